// File: rtl/display_pkg.sv
// Shared constants and helpers for the scanned 7-segment display driver and its monitors.
// Segment patterns are active-low, a..g in bits 7..1 and dp in bit 0.
package display_pkg;

    localparam int         N_DIGITS = 8;
    localparam logic [3:0] CODE_BAD = 4'hF;

    localparam logic [7:0] SEG_0     = 8'b0000_0011;
    localparam logic [7:0] SEG_1     = 8'b1001_1111;
    localparam logic [7:0] SEG_2     = 8'b0010_0101;
    localparam logic [7:0] SEG_3     = 8'b0000_1101;
    localparam logic [7:0] SEG_4     = 8'b1001_1001;
    localparam logic [7:0] SEG_5     = 8'b0100_1001;
    localparam logic [7:0] SEG_6     = 8'b0100_0001;
    localparam logic [7:0] SEG_7     = 8'b0001_1111;
    localparam logic [7:0] SEG_8     = 8'b0000_0001;
    localparam logic [7:0] SEG_9     = 8'b0000_1001;
    localparam logic [7:0] SEG_BLANK = 8'b1111_1111;

    typedef enum logic [1:0] {SLOT_BLANK, SLOT_ONE, SLOT_MULTI} slot_kind_t;

    typedef struct packed {
        slot_kind_t kind;
        logic [2:0] idx;
    } slot_t;

    typedef enum logic {ST_IDLE, ST_COLLECT} cap_state_t;

    // Classify an active-low enable bus: no digit, exactly one digit, or a driver fault.
    function automatic slot_t classify_en(input logic [N_DIGITS-1:0] en);
        slot_t r;
        int    zeros;
        r.kind = SLOT_BLANK;
        r.idx  = 3'd0;
        zeros  = 0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!en[i]) begin
                zeros++;
                r.idx = 3'(i);
            end
        end
        if (zeros == 1)
            r.kind = SLOT_ONE;
        else if (zeros > 1)
            r.kind = SLOT_MULTI;
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment to BCD decoder; dp is not an input.
// Blank decodes to CODE_BAD with ok=1; any unknown pattern gives CODE_BAD with ok=0.
module seg7_decode
    import display_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       ok
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        code = CODE_BAD;
        ok   = 1'b1;
        case (seg)
            SEG_0[7:1]:     code = 4'd0;
            SEG_1[7:1]:     code = 4'd1;
            SEG_2[7:1]:     code = 4'd2;
            SEG_3[7:1]:     code = 4'd3;
            SEG_4[7:1]:     code = 4'd4;
            SEG_5[7:1]:     code = 4'd5;
            SEG_6[7:1]:     code = 4'd6;
            SEG_7[7:1]:     code = 4'd7;
            SEG_8[7:1]:     code = 4'd8;
            SEG_9[7:1]:     code = 4'd9;
            SEG_BLANK[7:1]: code = CODE_BAD;
            default:        ok   = 1'b0;
        endcase
    end

endmodule

// File: rtl/display_capture.sv
// Rebuilds the 8-digit BCD image from the multiplexed display buses: debounce each scan
// slot, decode it, collect until every digit is seen, then publish the frame atomically.
module display_capture
    import display_pkg::*;
#(
    parameter int STABLE_CYC = 4,
    parameter int TIMEOUT    = 1024,
    parameter int TO_W       = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic [7:0]              led_en,
    input  logic [7:0]              led_cx,
    output logic [4*N_DIGITS-1:0]   digits,
    output logic [N_DIGITS-1:0]     digit_ok,
    output logic                    frame_done,
    output logic                    active,
    output logic                    en_err
);

    localparam int STAB_W = $clog2(STABLE_CYC) + 1;

    logic [7:0]            s_en, s_cx;
    logic [STAB_W-1:0]     stab;
    logic                  done_slot;
    logic                  same, eval;
    slot_t                 slot;
    logic [3:0]            dec_code;
    logic                  dec_ok;

    logic                  cmt_v, cmt_ok;
    logic [2:0]            cmt_idx;
    logic [3:0]            cmt_code;
    logic                  commit, publish, timeout_hit;

    logic [4*N_DIGITS-1:0] shadow;
    logic [N_DIGITS-1:0]   shadow_ok, seen;
    logic [TO_W-1:0]       to_cnt;
    cap_state_t            state, state_nx;

    seg7_decode u_dec (
        .seg  (s_cx[7:1]),
        .code (dec_code),
        .ok   (dec_ok)
    );

    assign slot = classify_en(s_en);
    assign same = ({led_en, led_cx} == {s_en, s_cx});
    assign eval = same && (stab == STAB_W'(STABLE_CYC - 1)) && !done_slot;

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses <= so every register sees pre-edge values.
        if (!rst) begin
            s_en      <= 8'hFF;
            s_cx      <= 8'hFF;
            stab      <= '0;
            done_slot <= 1'b0;
        end else begin
            s_en <= led_en;
            s_cx <= led_cx;
            if (!same) begin
                stab      <= '0;
                done_slot <= 1'b0;
            end else if (stab < STAB_W'(STABLE_CYC - 1)) begin
                stab <= stab + 1'b1;
            end else if (!done_slot) begin
                done_slot <= 1'b1;
            end
        end
    end

    // Registered decode result: a single-digit slot becomes a commit one cycle after evaluation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmt_v    <= 1'b0;
            cmt_idx  <= 3'd0;
            cmt_code <= 4'd0;
            cmt_ok   <= 1'b0;
            en_err   <= 1'b0;
        end else begin
            cmt_v    <= eval && (slot.kind == SLOT_ONE);
            cmt_idx  <= slot.idx;
            cmt_code <= dec_code;
            cmt_ok   <= dec_ok;
            if (clr)
                en_err <= 1'b0;
            else if (eval && (slot.kind == SLOT_MULTI))
                en_err <= 1'b1;
        end
    end

    assign commit      = cmt_v && !clr;
    assign publish     = (state == ST_COLLECT) && (seen == '1) && !clr;
    assign timeout_hit = (state == ST_COLLECT) && !commit && !publish
                         && (to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the shadow frame is reset too, so a reset mid-frame can never leak old digits.
            shadow     <= '0;
            shadow_ok  <= '0;
            seen       <= '0;
            to_cnt     <= '0;
            digits     <= '0;
            digit_ok   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= publish;
            if (commit) begin
                shadow[4*cmt_idx +: 4] <= cmt_code;
                shadow_ok[cmt_idx]     <= cmt_ok;
            end
            if (publish) begin
                digits   <= shadow;
                digit_ok <= shadow_ok;
            end

            if (clr || timeout_hit)
                seen <= '0;
            else if (publish)
                seen <= commit ? (N_DIGITS'(1) << cmt_idx) : '0;
            else if (commit)
                seen[cmt_idx] <= 1'b1;

            if (clr || commit || timeout_hit || state == ST_IDLE)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        active   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (commit)
                    state_nx = ST_COLLECT;
            end
            ST_COLLECT: begin
                active = 1'b1;
                if (timeout_hit)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        if (clr)
            state_nx = ST_IDLE;
    end

endmodule

// File: tb/tb_display_capture.sv
// Directed bench for display_capture: table of full scans with hand-computed frames,
// then hand-written sequences for latency, glitch, double enable, timeout and reset.
module tb_display_capture;
    import display_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  led_en = 8'hFF;
    logic [7:0]  led_cx = 8'hFF;
    logic [31:0] digits;
    logic [7:0]  digit_ok;
    logic        frame_done;
    logic        active;
    logic        en_err;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;

    display_capture #(.STABLE_CYC(4), .TIMEOUT(1024), .TO_W(11)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .led_en     (led_en),
        .led_cx     (led_cx),
        .digits     (digits),
        .digit_ok   (digit_ok),
        .frame_done (frame_done),
        .active     (active),
        .en_err     (en_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (frame_done === 1'b1) fd_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [63:0] cx;
        logic [31:0] exp_digits;
        logic [7:0]  exp_ok;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic hold(input logic [7:0] en, input logic [7:0] cx, input int n);
        led_en = en;
        led_cx = cx;
        repeat (n) @(negedge clk);
    endtask

    task automatic slot(input int i, input logic [7:0] cx);
        logic [7:0] one;
        one = 8'h01;
        hold(~(one << i), cx, 10);
    endtask

    task automatic scan(input logic [63:0] cxs);
        for (int i = 0; i < 8; i++) slot(i, cxs[8*i +: 8]);
        hold(8'hFF, 8'hFF, 10);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
    endtask

    vec_t vecs[4];
    int   fd0;
    int   lat;

    initial begin
        // Slot 7 is the most significant byte of cx and nibble of digits.
        vecs[0].cx = {SEG_0, SEG_0, SEG_0, SEG_0, SEG_0, SEG_4, SEG_0, SEG_4};
        vecs[0].exp_digits = 32'h0000_0404;
        vecs[0].exp_ok     = 8'hFF;
        vecs[1].cx = {SEG_7 & 8'hFE, SEG_6, SEG_5 & 8'hFE, SEG_4, SEG_3 & 8'hFE, SEG_2, SEG_1 & 8'hFE, SEG_0};
        vecs[1].exp_digits = 32'h7654_3210;
        vecs[1].exp_ok     = 8'hFF;
        vecs[2].cx = {SEG_3, SEG_1, SEG_6, SEG_5, SEG_BLANK, 8'b0110_0001, SEG_8, SEG_9};
        vecs[2].exp_digits = 32'h3165_FF89;
        vecs[2].exp_ok     = 8'hFB;
        vecs[3].cx = {SEG_0, SEG_9, SEG_BLANK, SEG_BLANK, SEG_7, SEG_7, SEG_2, SEG_2};
        vecs[3].exp_digits = 32'h09FF_7722;
        vecs[3].exp_ok     = 8'hFF;

        repeat (3) @(negedge clk);
        check("reset digits", digits, 32'h0);
        check("reset digit_ok", {24'h0, digit_ok}, 32'h0);
        check("reset frame_done", {31'h0, frame_done}, 32'h0);
        check("reset active", {31'h0, active}, 32'h0);
        check("reset en_err", {31'h0, en_err}, 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            fd0 = fd_cnt;
            scan(vecs[v].cx);
            check($sformatf("v%0d frames", v), 32'(fd_cnt - fd0), 32'd1);
            check($sformatf("v%0d digits", v), digits, vecs[v].exp_digits);
            check($sformatf("v%0d digit_ok", v), {24'h0, digit_ok}, {24'h0, vecs[v].exp_ok});
            check($sformatf("v%0d active", v), {31'h0, active}, 32'h1);
        end

        // Latency of the final slot: drive at a negedge, frame_done seen on the 7th negedge.
        for (int i = 0; i < 7; i++) slot(i, SEG_1);
        led_en = 8'h7F;
        led_cx = SEG_2;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (frame_done) begin
                lat = k;
                break;
            end
        end
        check("latency", 32'(lat), 32'd7);
        @(negedge clk);
        check("frame_done one cycle", {31'h0, frame_done}, 32'h0);
        check("latency digits", digits, 32'h2111_1111);
        hold(8'hFF, 8'hFF, 10);

        pulse_clr();
        check("clr active", {31'h0, active}, 32'h0);
        check("clr holds digits", digits, 32'h2111_1111);

        // Glitch shorter than the debounce window is never committed.
        fd0 = fd_cnt;
        hold(8'hF7, SEG_5, 3);
        hold(8'hFF, 8'hFF, 10);
        check("glitch no commit", {31'h0, active}, 32'h0);
        slot(3, SEG_5);
        hold(8'hFF, 8'hFF, 5);
        check("stable slot commit", {31'h0, active}, 32'h1);
        check("glitch no frame", 32'(fd_cnt - fd0), 32'd0);
        pulse_clr();

        hold(8'hFC, SEG_1, 10);
        check("double en_err", {31'h0, en_err}, 32'h1);
        check("double no commit", {31'h0, active}, 32'h0);
        pulse_clr();
        check("clr en_err", {31'h0, en_err}, 32'h0);

        // Partial frame with an overwrite, then abandoned by timeout.
        fd0 = fd_cnt;
        slot(0, SEG_1);
        slot(1, SEG_3);
        slot(2, SEG_2);
        slot(1, SEG_7);
        slot(3, SEG_4);
        slot(4, SEG_8);
        check("partial active", {31'h0, active}, 32'h1);
        hold(8'hFF, 8'hFF, 1000);
        check("before timeout active", {31'h0, active}, 32'h1);
        hold(8'hFF, 8'hFF, 100);
        check("after timeout active", {31'h0, active}, 32'h0);
        check("timeout no frame", 32'(fd_cnt - fd0), 32'd0);
        check("timeout digits held", digits, 32'h2111_1111);
        fd0 = fd_cnt;
        scan({SEG_9, SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6});
        check("rescan frames", 32'(fd_cnt - fd0), 32'd1);
        check("rescan digits", digits, 32'h9012_3456);

        // Reset mid-frame: outputs clear at once and the partial seen mask is discarded.
        for (int i = 0; i < 4; i++) slot(i, SEG_8);
        #2;
        rst = 1'b0;
        #1;
        check("midreset digits", digits, 32'h0);
        check("midreset active", {31'h0, active}, 32'h0);
        check("midreset digit_ok", {24'h0, digit_ok}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        fd0 = fd_cnt;
        for (int i = 4; i < 8; i++) slot(i, SEG_8);
        hold(8'hFF, 8'hFF, 10);
        check("midreset seen discarded", 32'(fd_cnt - fd0), 32'd0);
        check("midreset collecting", {31'h0, active}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_capture.md
Name: display_capture

Overview:
- Receiver for the scanned 7-segment display interface: samples the multiplexed digit-enable and segment buses and reconstructs the 8-digit image as BCD.
- Debounces each scan slot, decodes the segment pattern, and collects slots until all 8 have been seen.
- Publishes a whole frame atomically with a one-cycle strobe.
- Used as an on-board self-check and simulation monitor of the display driver output.

Parameters:
- STABLE_CYC, 4: consecutive matching samples required before a slot is accepted (must be less than the driver dwell, currently 10).
- TIMEOUT, 1024: cycles without an accepted slot before frame collection is abandoned.
- TO_W, 11: width of the timeout counter (must satisfy 2^TO_W > TIMEOUT).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous clear of en_err, the seen mask and the timeout counter.
- led_en  in  8  digit enable, active-low; bit i selects digit i.
- led_cx  in  8  segments, active-low; bit7..bit1 = a..g, bit0 = dp.
- digits  out  32  last complete frame; digit i occupies [4i+3:4i].
- digit_ok  out  8  bit i = 1 when digit i of the last frame decoded to 0-9 or blank.
- frame_done  out  1  one-cycle pulse when digits/digit_ok update.
- active  out  1  1 while a frame is being collected.
- en_err  out  1  sticky flag: more than one enable low, stable for STABLE_CYC.

Behaviour:
- Reset (rst=0, async) clears all registers:
  - digits=0, digit_ok=0, frame_done=0, active=0, en_err=0.
  - seen=0, state=IDLE.
- Input stage: {led_en,led_cx} registered every cycle into s_en/s_cx (one sample stage).
- Stability counter stab (width ceil(log2(STABLE_CYC))+1) and flag done_slot:
  - Input differs from sample: stab<=0, done_slot<=0.
  - Otherwise, when stab < STABLE_CYC-1: stab++.
  - Otherwise, when stab == STABLE_CYC-1 and done_slot==0: evaluate the slot and set done_slot<=1.
  - Net effect: each stable dwell is evaluated exactly once.
- Slot evaluation, classified by s_en:
  - All ones: blank period; ignored, no commit.
  - Exactly one zero at bit i: commit slot i.
  - Two or more zeros: en_err<=1, no commit.
- Decode ignores dp (bit0). Match on cx[7:1]; anything else gives code F, ok=0:
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4
  - 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9
  - 1111111=blank, code F, ok=1
- Commit of slot i:
  - shadow[i] <= code, shadow_ok[i] <= ok, seen[i] <= 1.
  - Timeout counter <= 0.
  - Recommitting a slot already seen overwrites it; last value wins and it is counted once.
- State machine:
  - IDLE: active=0. Any commit goes to COLLECT.
  - COLLECT: active=1.
    - If a commit makes seen == 8'hFF, the next edge does all of: digits<=shadow (including this commit), digit_ok<=shadow_ok, frame_done<=1 for one cycle, seen<=0, and the state stays COLLECT.
    - Timeout counter increments each cycle without a commit. When it reaches TIMEOUT-1: seen<=0, state<=IDLE. digits are unchanged.
- clr:
  - Clears en_err, seen and the timeout counter, and forces IDLE. digits and digit_ok are held.
  - clr wins over a commit in the same cycle.
- Latency: frame_done rises 2 cycles after the edge that first samples the final stable slot value, plus STABLE_CYC.
- Simultaneous events: a commit that completes the frame in the same cycle the timeout would fire completes the frame; commit has priority over timeout.
- Reset mid-frame discards the shadow and seen mask.

Decomposition:
- Shared package display_pkg holds:
  - The 7-segment constants SEG_0..SEG_9 and SEG_BLANK (8-bit, active-low, dp in bit0), the same values the display driver uses.
  - N_DIGITS=8, CODE_BAD=4'hF.
- One sub-module, seg7_decode: combinational cx[7:1] → {code[3:0], ok}. It is reusable by other monitors.

Test Plan:
- Reset: assert rst=0 mid-operation → all outputs 0, active=0 at the next sample.
- Full scan, 10-cycle dwell, slots 0..7 = 4,0,4,0,0,0,0,0 (cx 10011001 / 00000011) → one frame_done pulse; digits=32'h0000_0404; digit_ok=8'hFF.
- Glitch: slot 3 pattern held for STABLE_CYC-1 cycles then changed → seen[3] stays 0, no commit; held for 10 cycles → committed.
- Double enable: led_en=8'b1111_1100 held 10 cycles → en_err=1, no commit; pulse clr → en_err=0.
- Bad pattern: slot 2 cx=8'b0110_0001 within a full scan → digits[11:8]=4'hF, digit_ok[2]=0, frame_done still pulses.
- Timeout/overwrite: commit slots 0-4 (slot 1 twice, values 3 then 7), then idle TIMEOUT cycles → active=0 and no frame; then a full scan → frame_done, and digits[7:4] reflects only the new scan.
